// File: rtl/adc_trig_frontend_pkg.sv
// Shared acquisition definitions for the ADC front end and capture stage.
// Holds the lock FSM encoding, the ADC bus width and lock defaults.
package adc_trig_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        LOCKING,
        STABLE
    } acq_state_t;

    localparam int ADC_WIDTH        = 12;
    localparam int DEF_STABLE_COUNT = 4;
    localparam int DEF_TOL_SHIFT    = 4;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs into the clk domain.
// Ports: clk, rst (async high), d (raw input), q (synchronised, 2-cycle latency).
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/adc_trig_frontend.sv
// ADC front end: sample-clock divider, input synchronisers, comparator
// period measurement and frequency-lock detection.
// Ports: clk, rst (async high), div_cfg (adc_clk half-period),
//   adc_data_in / cmp_in (async inputs), adc_clk, sync_adc_data,
//   sync_signal_in, stable, period, period_valid.
module adc_trig_frontend
    import adc_trig_frontend_pkg::*;
#(
    parameter int DIV_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 24,
    parameter int STABLE_COUNT = DEF_STABLE_COUNT,
    parameter int TOL_SHIFT    = DEF_TOL_SHIFT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIV_WIDTH-1:0]    div_cfg,
    input  logic [ADC_WIDTH-1:0]    adc_data_in,
    input  logic                    cmp_in,
    output logic                    adc_clk,
    output logic [ADC_WIDTH-1:0]    sync_adc_data,
    output logic                    sync_signal_in,
    output logic                    stable,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid
);

    localparam int MW = $clog2(STABLE_COUNT + 1);

    localparam logic [DIV_WIDTH-1:0]    DIV_ONE  = 1;
    localparam logic [PERIOD_WIDTH-1:0] PER_ONE  = 1;
    localparam logic [PERIOD_WIDTH:0]   DIFF_ONE = 1;
    localparam logic [MW-1:0]           MC_ONE   = 1;
    localparam logic [MW-1:0]           MC_TGT   = MW'(STABLE_COUNT);

    // ---------------- divider ----------------
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] cur_div;
    logic [DIV_WIDTH-1:0] eff_cfg;
    logic [DIV_WIDTH-1:0] lim;
    logic                 div_term;
    logic                 adc_fall;

    assign eff_cfg = (div_cfg == '0) ? DIV_ONE : div_cfg;
    // cur_div is zero only before the first toggle after reset; the
    // first phase then follows div_cfg directly.
    assign lim      = (cur_div == '0) ? eff_cfg : cur_div;
    assign div_term = (div_cnt >= lim - DIV_ONE);
    assign adc_fall = div_term & adc_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            cur_div <= '0;
            adc_clk <= 1'b0;
        end else if (div_term) begin
            div_cnt <= '0;
            cur_div <= eff_cfg;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt + DIV_ONE;
        end
    end

    // ---------------- ADC path ----------------
    logic [ADC_WIDTH-1:0] adc_s2;

    sync_2ff #(.W(ADC_WIDTH)) u_adc_sync (
        .clk (clk),
        .rst (rst),
        .d   (adc_data_in),
        .q   (adc_s2)
    );

    // Loading on the falling edge keeps the word steady across the
    // whole low and high phase around each rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_adc_data <= '0;
        end else if (adc_fall) begin
            sync_adc_data <= adc_s2;
        end
    end

    // ---------------- comparator path ----------------
    logic cmp_prev;
    logic rise;

    sync_2ff #(.W(1)) u_cmp_sync (
        .clk (clk),
        .rst (rst),
        .d   (cmp_in),
        .q   (sync_signal_in)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmp_prev <= 1'b0;
        end else begin
            cmp_prev <= sync_signal_in;
        end
    end

    assign rise = sync_signal_in & ~cmp_prev;

    // ---------------- period / lock FSM ----------------
    acq_state_t              state, state_d;
    logic [PERIOD_WIDTH-1:0] per_cnt, per_d;
    logic [PERIOD_WIDTH-1:0] ref_per, ref_d;
    logic [PERIOD_WIDTH-1:0] period_d;
    logic [MW-1:0]           match_cnt, match_d;
    logic                    pv_d;
    logic                    stable_d;

    logic                    saturated;
    logic                    timeout;
    logic [PERIOD_WIDTH-1:0] meas;
    logic [PERIOD_WIDTH:0]   diff;
    logic [PERIOD_WIDTH:0]   abs_diff;
    logic [PERIOD_WIDTH:0]   tol;
    logic                    is_match;

    assign saturated = &per_cnt;
    assign timeout   = (state != IDLE) & saturated;
    assign meas      = per_cnt + PER_ONE;

    // One extra bit so the difference never wraps.
    assign diff     = {1'b0, meas} - {1'b0, ref_per};
    assign abs_diff = diff[PERIOD_WIDTH] ? (~diff + DIFF_ONE) : diff;
    assign tol      = {1'b0, ref_per >> TOL_SHIFT};
    assign is_match = (abs_diff <= tol);

    always_comb begin
        state_d  = state;
        ref_d    = ref_per;
        match_d  = match_cnt;
        period_d = period;
        pv_d     = 1'b0;
        per_d    = saturated ? per_cnt : per_cnt + PER_ONE;
        if (state == IDLE) begin
            per_d = '0;
        end
        if (timeout) begin
            state_d = IDLE;
            per_d   = '0;
            match_d = '0;
        end else if (rise) begin
            per_d = '0;
            if (state != IDLE) begin
                period_d = meas;
                pv_d     = 1'b1;
            end
            unique case (state)
                IDLE: begin
                    state_d = MEASURE;
                end
                MEASURE: begin
                    ref_d   = meas;
                    match_d = '0;
                    state_d = LOCKING;
                end
                LOCKING: begin
                    if (is_match) begin
                        match_d = match_cnt + MC_ONE;
                        if (match_cnt + MC_ONE == MC_TGT) begin
                            state_d = STABLE;
                        end
                    end else begin
                        ref_d   = meas;
                        match_d = '0;
                    end
                end
                STABLE: begin
                    if (!is_match) begin
                        ref_d   = meas;
                        match_d = '0;
                        state_d = LOCKING;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        stable_d = (state_d == STABLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            per_cnt      <= '0;
            ref_per      <= '0;
            match_cnt    <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            stable       <= 1'b0;
        end else begin
            state        <= state_d;
            per_cnt      <= per_d;
            ref_per      <= ref_d;
            match_cnt    <= match_d;
            period       <= period_d;
            period_valid <= pv_d;
            stable       <= stable_d;
        end
    end

endmodule

// File: tb/tb_adc_trig_frontend.sv
// Randomised scoreboard bench for adc_trig_frontend.
// A cycle-indexed reference model predicts every output.
module tb_adc_trig_frontend;

    localparam int DW    = 16;
    localparam int PW    = 8;
    localparam int SCNT  = 4;
    localparam int TSH   = 4;
    localparam int TMO   = 1 << PW;
    localparam int HMAX  = 32768;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] div_cfg;
    logic [11:0]   adc_data_in;
    logic          cmp_in;
    logic          adc_clk;
    logic [11:0]   sync_adc_data;
    logic          sync_signal_in;
    logic          stable;
    logic [PW-1:0] period;
    logic          period_valid;

    adc_trig_frontend #(
        .DIV_WIDTH    (DW),
        .PERIOD_WIDTH (PW),
        .STABLE_COUNT (SCNT),
        .TOL_SHIFT    (TSH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .div_cfg        (div_cfg),
        .adc_data_in    (adc_data_in),
        .cmp_in         (cmp_in),
        .adc_clk        (adc_clk),
        .sync_adc_data  (sync_adc_data),
        .sync_signal_in (sync_signal_in),
        .stable         (stable),
        .period         (period),
        .period_valid   (period_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int effd(input logic [DW-1:0] d);
        return (d == 0) ? 1 : int'(d);
    endfunction

    // ---------------- reference model ----------------
    int          k;
    bit          hist_c [0:HMAX-1];
    logic [11:0] hist_d [0:HMAX-1];
    bit          m_adc, m_sync, m_stable, m_pv;
    logic [11:0] m_data;
    int          phase_end;
    int          mstate;
    int          last_rise, refp, mcnt;
    int          pq[$];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                k = 0;
                hist_c[0] = 1'b0;
                hist_d[0] = '0;
                m_adc = 0; m_sync = 0; m_stable = 0; m_pv = 0;
                m_data = '0;
                phase_end = 0;
                mstate = 0; last_rise = 0; refp = 0; mcnt = 0;
                pq.delete();
            end else begin
                bit rise, ok;
                int p, d;
                k++;
                if (k >= HMAX) begin
                    $display("FAIL model_history: cycle %0d over %0d", k, HMAX);
                    $fatal(1);
                end
                hist_c[k] = cmp_in;
                hist_d[k] = adc_data_in;
                if (k == 1) phase_end = effd(div_cfg);
                if (k == phase_end) begin
                    if (m_adc) m_data = hist_d[k-2];
                    m_adc = !m_adc;
                    phase_end = k + effd(div_cfg);
                end
                m_sync = hist_c[k-1];
                rise = (k >= 3) && hist_c[k-2] && !hist_c[k-3];
                m_pv = 0;
                if (mstate != 0 && k - last_rise >= TMO) begin
                    mstate = 0;
                end else if (rise) begin
                    if (mstate != 0) begin
                        p = k - last_rise;
                        m_pv = 1;
                        pq.push_back(p);
                        d = (p > refp) ? p - refp : refp - p;
                        ok = d <= (refp >> TSH);
                        case (mstate)
                            1: begin refp = p; mcnt = 0; mstate = 2; end
                            2: begin
                                if (ok) begin
                                    mcnt++;
                                    if (mcnt == SCNT) mstate = 3;
                                end else begin
                                    refp = p; mcnt = 0;
                                end
                            end
                            default: begin
                                if (!ok) begin
                                    refp = p; mcnt = 0; mstate = 2;
                                end
                            end
                        endcase
                    end else begin
                        mstate = 1;
                    end
                    last_rise = k;
                end
                m_stable = (mstate == 3);
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("adc_clk", int'(adc_clk), int'(m_adc));
                chk("sync_adc_data", int'(sync_adc_data), int'(m_data));
                chk("sync_signal_in", int'(sync_signal_in), int'(m_sync));
                chk("stable", int'(stable), int'(m_stable));
                chk("period_valid", int'(period_valid), int'(m_pv));
                if (period_valid) begin
                    if (pq.size() == 0) begin
                        chk("period_unexpected", 1, 0);
                    end else begin
                        chk("period", int'(period), pq.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        adc_data_in = 12'($urandom);
    endtask

    task automatic sq(input int p);
        cmp_in = 1'b1;
        repeat (p / 2) tick();
        cmp_in = 1'b0;
        repeat (p - p / 2) tick();
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        div_cfg = 16'd3;
        adc_data_in = '0;
        cmp_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_adc_clk", int'(adc_clk), 0);
        chk("rst_data", int'(sync_adc_data), 0);
        chk("rst_stable", int'(stable), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_pv", int'(period_valid), 0);
        chk("rst_sync", int'(sync_signal_in), 0);
        rst = 1'b0;

        // divider: 3, change to 5 mid-phase, then 0 and 1, then 4 with data
        repeat (14) tick();
        div_cfg = 16'd5;
        repeat (40) tick();
        div_cfg = 16'd0;
        repeat (20) tick();
        div_cfg = 16'd1;
        repeat (20) tick();
        div_cfg = 16'd4;
        repeat (60) tick();

        // lock on exact 100-cycle periods, then jitter inside tolerance
        repeat (8) sq(100);
        chk("locked_100", int'(stable), 1);
        repeat (10) sq($urandom_range(94, 106));
        chk("locked_jitter", int'(stable), 1);
        sq(100);

        // loss of lock on one 120 period, relock on four more
        sq(120);
        cmp_in = 1'b1;
        repeat (5) tick();
        chk("unlock_120", int'(stable), 0);
        repeat (55) tick();
        cmp_in = 1'b0;
        repeat (60) tick();
        repeat (4) sq(120);
        cmp_in = 1'b1;
        repeat (5) tick();
        chk("relock_120", int'(stable), 1);
        repeat (55) tick();
        cmp_in = 1'b0;
        repeat (60) tick();

        // timeout: comparator stops, then two rises only reach LOCKING
        repeat (6) sq(100);
        repeat (400) tick();
        chk("timeout_stable", int'(stable), 0);
        sq(100);
        sq(100);
        chk("after_timeout", int'(stable), 0);

        // random periods with occasional divider changes
        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 3) == 0) div_cfg = 16'($urandom_range(0, 6));
            sq($urandom_range(30, 200));
        end
        div_cfg = 16'd2;
        repeat (6) sq(80);

        // asynchronous reset while adc_clk is high
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (adc_clk) found = 1;
        end
        chk("found_adc_high", int'(found), 1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_adc_clk", int'(adc_clk), 0);
        chk("mid_rst_data", int'(sync_adc_data), 0);
        chk("mid_rst_stable", int'(stable), 0);
        chk("mid_rst_period", int'(period), 0);
        chk("mid_rst_pv", int'(period_valid), 0);
        chk("mid_rst_sync", int'(sync_signal_in), 0);
        repeat (2) @(negedge clk);
        div_cfg = 16'd3;
        rst = 1'b0;
        repeat (8) sq(90);
        chk("relock_after_rst", int'(stable), 1);
        repeat (10) tick();

        chk("queue_drained", pq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
